// File: rtl/tof_pkg.sv
// Shared types and constants for the TOF result buffer: the result word layout,
// the measurement FSM states and the fixed word that marks a missed hit.
package tof_pkg;

  localparam int TOF_W  = 23;
  localparam int WORD_W = TOF_W + 1;

  typedef struct packed {
    logic             timeout;
    logic [TOF_W-1:0] tof;
  } tof_word_t;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_HIT = 1'b1
  } meas_state_t;

  localparam tof_word_t TIMEOUT_WORD = '{timeout: 1'b1, tof: {TOF_W{1'b1}}};

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered read port. A read of an empty FIFO
// returns EMPTY_VAL without popping; a pop frees a slot for a push in the same cycle.
module sync_fifo #(
  parameter int             W         = 24,
  parameter int             DEPTH     = 4,
  parameter logic [W-1:0]   EMPTY_VAL = '1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [W-1:0]  r_rdata;
  logic          w_full;
  logic          w_empty;
  logic          w_do_pop;
  logic          w_do_push;

  assign w_full    = (r_level == LW'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_rdata <= '0;
    end else begin
      if (i_pop) r_rdata <= w_empty ? EMPTY_VAL : r_mem[r_rptr];
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_rdata;
  assign o_level = r_level;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/tof_result_buffer.sv
// Measurement sequencer and result queue between the TDC core and the SPI readout.
//   state    | meaning
//   IDLE     | no measurement pending, hits ignored
//   WAIT_HIT | armed after start, waiting for a hit or the timeout
module tof_result_buffer #(
  parameter int                DATA_W      = 24,
  parameter int                DEPTH       = 4,
  parameter int                TIMEOUT_CYC = 1000,
  parameter logic [DATA_W-1:0] EMPTY_WORD  = {DATA_W{1'b1}}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_pulse,
  input  logic                     tof_valid,
  input  logic [22:0]              tof_value,
  input  logic                     rd_req,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_ack,
  input  logic                     int_en,
  input  logic                     int_clr,
  output logic                     INT0,
  output logic                     INT1,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               drop_cnt,
  output logic                     busy
);

  import tof_pkg::*;

  localparam int                LW       = $clog2(DEPTH) + 1;
  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

  meas_state_t      r_state;
  meas_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_push;
  tof_word_t        w_word;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  logic [LW-1:0]    w_level;
  logic             r_rd_ack;
  logic             r_int0;
  logic             r_int1;
  logic [7:0]       r_drop_cnt;

  // The timer counts down the cycles remaining; reaching zero is the expiry cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_word      = '{timeout: 1'b0, tof: tof_value};
    case (r_state)
      IDLE: begin
        if (start_pulse) begin
          w_state_nxt = WAIT_HIT;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT_HIT: begin
        if (tof_valid) begin
          w_push      = 1'b1;
          w_state_nxt = start_pulse ? WAIT_HIT : IDLE;
          w_cnt_nxt   = CNT_LOAD;
        end else if (start_pulse) begin
          w_cnt_nxt   = CNT_LOAD;
        end else if (r_cnt == '0) begin
          w_push      = 1'b1;
          w_word      = TIMEOUT_WORD;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A same-cycle read frees a slot, so a push into a full FIFO is only dropped without one.
  assign w_drop = w_push & w_full & ~(rd_req & ~w_empty);

  sync_fifo #(
    .W         (DATA_W),
    .DEPTH     (DEPTH),
    .EMPTY_VAL (EMPTY_WORD)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_word),
    .i_pop   (rd_req),
    .o_rdata (rd_data),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rd_ack   <= 1'b0;
      r_int0     <= 1'b0;
      r_int1     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rd_ack <= rd_req;
      r_int0   <= int_en & (w_level != '0);
      // Overflow takes priority over a simultaneous clear.
      if (w_drop) begin
        r_int1     <= 1'b1;
        r_drop_cnt <= int_clr ? 8'd1 : ((r_drop_cnt == 8'hFF) ? r_drop_cnt : r_drop_cnt + 8'd1);
      end else if (int_clr) begin
        r_int1     <= 1'b0;
        r_drop_cnt <= '0;
      end
    end
  end

  assign rd_ack     = r_rd_ack;
  assign INT0       = r_int0;
  assign INT1       = r_int1;
  assign fifo_level = w_level;
  assign drop_cnt   = r_drop_cnt;
  assign busy       = (r_state == WAIT_HIT);

endmodule
